// File: rtl/entity_collision_checker.sv
`default_nettype none
// ============================================================================
//  Module   : entity_collision_checker
//  Purpose  : Scans a snapshot of the shot and asteroid entity arrays once per
//             start pulse, one (asteroid, shot) pair per cycle, and issues
//             paired delete pulses for every overlap plus a saturating hit
//             count for scoring.
//  Ports    : clk              - system clock, rising edge
//             reset_n          - asynchronous reset, active HIGH (despite name)
//             start            - begin a scan, honoured only when idle
//             shots_data       - packed shots, slot i at [i*ENTITY_SIZE +: ENTITY_SIZE]
//             asteroids_data   - packed asteroids, same packing
//             delete_shot      - one-cycle pulse, clear shot slot shot_address
//             shot_address     - shot slot index (holds between pulses)
//             delete_asteroid  - one-cycle pulse, clear asteroid slot asteroid_address
//             asteroid_address - asteroid slot index (holds between pulses)
//             hit_count        - cumulative hits, saturates at 255
//             busy             - scan in progress
//             done             - one-cycle pulse at scan end
//  Revision : 1.0 - initial release
// ============================================================================
module entity_collision_checker #(
  parameter int SHOT_COUNT     = 10,
  parameter int ASTEROID_COUNT = 4,
  parameter int ENTITY_SIZE    = 34,
  parameter int ASTEROID_SIZE  = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [SHOT_COUNT*ENTITY_SIZE-1:0]      shots_data,
  input  logic [ASTEROID_COUNT*ENTITY_SIZE-1:0]  asteroids_data,
  output logic                                   delete_shot,
  output logic [$clog2(SHOT_COUNT)-1:0]          shot_address,
  output logic                                   delete_asteroid,
  output logic [$clog2(ASTEROID_COUNT)-1:0]      asteroid_address,
  output logic [7:0]                             hit_count,
  output logic                                   busy,
  output logic                                   done
);

  localparam int SW = $clog2(SHOT_COUNT);
  localparam int AW = $clog2(ASTEROID_COUNT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_HIT     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [SW-1:0] LAST_S = SW'(SHOT_COUNT - 1);
  localparam logic [AW-1:0] LAST_A = AW'(ASTEROID_COUNT - 1);
  localparam logic [10:0]   HB     = 11'(ASTEROID_SIZE);

  // Entity field positions (only valid, x and y are used here)
  localparam int VLD_BIT = 33;
  localparam int Y_LSB   = 16;
  localparam int X_LSB   = 6;

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [AW-1:0]       a_q, a_d;
  logic [SW-1:0]       shot_address_q, shot_address_d;
  logic [AW-1:0]       asteroid_address_q, asteroid_address_d;
  logic [7:0]          hit_count_q, hit_count_d;

  // Snapshot: only the fields the comparison needs
  logic [SHOT_COUNT-1:0]     shot_vld_q, shot_vld_d;
  logic [9:0]                shot_x_q [SHOT_COUNT];
  logic [9:0]                shot_y_q [SHOT_COUNT];
  logic [ASTEROID_COUNT-1:0] ast_vld_q, ast_vld_d;
  logic [9:0]                ast_x_q [ASTEROID_COUNT];
  logic [9:0]                ast_y_q [ASTEROID_COUNT];

  // Live input fields, unpacked for the capture in IDLE
  logic [SHOT_COUNT-1:0]     live_shot_vld;
  logic [9:0]                live_shot_x [SHOT_COUNT];
  logic [9:0]                live_shot_y [SHOT_COUNT];
  logic [ASTEROID_COUNT-1:0] live_ast_vld;
  logic [9:0]                live_ast_x [ASTEROID_COUNT];
  logic [9:0]                live_ast_y [ASTEROID_COUNT];

  genvar gi;
  generate
    for (gi = 0; gi < SHOT_COUNT; gi++) begin : g_shot_unpack
      assign live_shot_vld[gi] = shots_data[gi*ENTITY_SIZE + VLD_BIT];
      assign live_shot_x[gi]   = shots_data[gi*ENTITY_SIZE + X_LSB +: 10];
      assign live_shot_y[gi]   = shots_data[gi*ENTITY_SIZE + Y_LSB +: 10];
    end
    for (gi = 0; gi < ASTEROID_COUNT; gi++) begin : g_ast_unpack
      assign live_ast_vld[gi] = asteroids_data[gi*ENTITY_SIZE + VLD_BIT];
      assign live_ast_x[gi]   = asteroids_data[gi*ENTITY_SIZE + X_LSB +: 10];
      assign live_ast_y[gi]   = asteroids_data[gi*ENTITY_SIZE + Y_LSB +: 10];
    end
  endgenerate

  // Pair evaluation; bounds are widened to 11 bits so ax+SIZE never wraps
  logic        hit;
  logic        last_pair;
  logic [10:0] sx, sy, ax, ay;

  always_comb begin
    sx = {1'b0, shot_x_q[s_q]};
    sy = {1'b0, shot_y_q[s_q]};
    ax = {1'b0, ast_x_q[a_q]};
    ay = {1'b0, ast_y_q[a_q]};
    hit = ast_vld_q[a_q] & shot_vld_q[s_q] &
          (sx >= ax) & (sx < ax + HB) &
          (sy >= ay) & (sy < ay + HB);
    last_pair = (a_q == LAST_A) && (s_q == LAST_S);
  end

  // State register
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (hit)            state_d = ST_HIT;
        else if (last_pair) state_d = ST_DONE;
      end
      ST_HIT:     state_d = last_pair ? ST_DONE : ST_COMPARE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    delete_shot      = (state_q == ST_HIT);
    delete_asteroid  = (state_q == ST_HIT);
    busy             = (state_q == ST_COMPARE) || (state_q == ST_HIT);
    done             = (state_q == ST_DONE);
    shot_address     = shot_address_q;
    asteroid_address = asteroid_address_q;
    hit_count        = hit_count_q;
  end

  // Datapath next values
  always_comb begin
    s_d                = s_q;
    a_d                = a_q;
    shot_address_d     = shot_address_q;
    asteroid_address_d = asteroid_address_q;
    hit_count_d        = hit_count_q;
    shot_vld_d         = shot_vld_q;
    ast_vld_d          = ast_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d        = '0;
          a_d        = '0;
          shot_vld_d = live_shot_vld;
          ast_vld_d  = live_ast_vld;
        end
      end
      ST_COMPARE: begin
        if (hit) begin
          // Index is held here and advanced in HIT
          shot_address_d     = s_q;
          asteroid_address_d = a_q;
        end else if (s_q == LAST_S) begin
          s_d = '0;
          a_d = a_q + AW'(1);
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      ST_HIT: begin
        // Retire both entities so neither can take part in another hit
        shot_vld_d[shot_address_q]    = 1'b0;
        ast_vld_d[asteroid_address_q] = 1'b0;
        if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
        if (s_q == LAST_S) begin
          s_d = '0;
          a_d = a_q + AW'(1);
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; positions only load on the IDLE capture
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      s_q                <= '0;
      a_q                <= '0;
      shot_address_q     <= '0;
      asteroid_address_q <= '0;
      hit_count_q        <= '0;
      shot_vld_q         <= '0;
      ast_vld_q          <= '0;
      for (int i = 0; i < SHOT_COUNT; i++) begin
        shot_x_q[i] <= '0;
        shot_y_q[i] <= '0;
      end
      for (int i = 0; i < ASTEROID_COUNT; i++) begin
        ast_x_q[i] <= '0;
        ast_y_q[i] <= '0;
      end
    end else begin
      s_q                <= s_d;
      a_q                <= a_d;
      shot_address_q     <= shot_address_d;
      asteroid_address_q <= asteroid_address_d;
      hit_count_q        <= hit_count_d;
      shot_vld_q         <= shot_vld_d;
      ast_vld_q          <= ast_vld_d;
      if (state_q == ST_IDLE && start) begin
        for (int i = 0; i < SHOT_COUNT; i++) begin
          shot_x_q[i] <= live_shot_x[i];
          shot_y_q[i] <= live_shot_y[i];
        end
        for (int i = 0; i < ASTEROID_COUNT; i++) begin
          ast_x_q[i] <= live_ast_x[i];
          ast_y_q[i] <= live_ast_y[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_entity_collision_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entity_collision_checker
//  Purpose  : Directed self-checking bench for entity_collision_checker.
//             Cycle k below means the cycle after the k-th rising edge
//             following the edge that sampled start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_entity_collision_checker;

  localparam int SC = 10;
  localparam int AC = 4;
  localparam int ES = 34;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [SC*ES-1:0] shots;
  logic [AC*ES-1:0] asts;
  logic             delete_shot;
  logic [3:0]       shot_address;
  logic             delete_asteroid;
  logic [1:0]       asteroid_address;
  logic [7:0]       hit_count;
  logic             busy;
  logic             done;

  entity_collision_checker #(
    .SHOT_COUNT(SC), .ASTEROID_COUNT(AC), .ENTITY_SIZE(ES), .ASTEROID_SIZE(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .shots_data(shots), .asteroids_data(asts),
    .delete_shot(delete_shot), .shot_address(shot_address),
    .delete_asteroid(delete_asteroid), .asteroid_address(asteroid_address),
    .hit_count(hit_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;

  // Scan monitor results
  int n_del, del_at, n_done, done_at, busy_cnt, busy_first, busy_last, pair_err;
  int last_sa, last_aa;
  // Scan monitor options
  int mon_start_k, mon_rst_k;
  bit mon_alt;
  logic [SC*ES-1:0] alt_shots;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [ES-1:0] ent(input logic v, input int x, input int y);
    logic [9:0] xx, yy;
    xx = x[9:0];
    yy = y[9:0];
    // Non-zero type/step/direction bits must be ignored by the DUT
    return {v, 3'b101, 2'b01, 2'b10, yy, xx, 6'h2a};
  endfunction

  task automatic clear_all();
    shots = '0;
    asts = '0;
    mon_start_k = 0;
    mon_rst_k = 0;
    mon_alt = 1'b0;
    alt_shots = '0;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Pulse start, then watch 50 cycles and record what happened
  task automatic scan();
    n_del = 0; del_at = -1; n_done = 0; done_at = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1; pair_err = 0;
    last_sa = -1; last_aa = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (done) begin
        n_done++;
        done_at = k;
      end
      if (delete_shot !== delete_asteroid) pair_err++;
      if (delete_shot) begin
        n_del++;
        if (n_del == 1) del_at = k;
        last_sa = int'(shot_address);
        last_aa = int'(asteroid_address);
      end
      if (mon_alt && k == 5) shots = alt_shots;
      start = (k == mon_start_k - 1);
      if (k == mon_rst_k - 1) begin
        reset_n = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_del", {delete_shot, delete_asteroid}, 0);
        check("rst_hits", hit_count, 0);
      end
      if (mon_rst_k != 0 && k == mon_rst_k) reset_n = 1'b0;
    end
  endtask

  int bx [8] = '{100, 100, 100, 100, 100, 100, 1020, 1020};
  int by [8] = '{100, 100, 100, 100, 100, 100, 100, 100};
  int sxv[8] = '{115, 116,  99, 100, 100, 100, 1023,    2};
  int syv[8] = '{115, 100, 100, 116,  99, 100,  110,  110};
  int bh [8] = '{  1,   0,   0,   0,   0,   1,    1,    0};

  int total_del;

  initial begin
    clear_all();
    reset_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dels", {delete_shot, delete_asteroid}, 0);
    check("reset_addr", {shot_address, asteroid_address}, 0);
    check("reset_hits", hit_count, 0);
    reset_n = 1'b0;

    // All invalid (positions overlap, but valid bits are clear)
    clear_all();
    asts[0*ES +: ES]  = ent(1'b0, 100, 100);
    shots[0*ES +: ES] = ent(1'b0, 105, 105);
    asts[1*ES +: ES]  = ent(1'b1, 200, 200);
    shots[1*ES +: ES] = ent(1'b0, 205, 205);
    scan();
    check("inv_ndel", n_del, 0);
    check("inv_busy_cnt", busy_cnt, 40);
    check("inv_busy_first", busy_first, 1);
    check("inv_busy_last", busy_last, 40);
    check("inv_done_at", done_at, 41);
    check("inv_ndone", n_done, 1);
    check("inv_hits", hit_count, 0);

    // Single hit: asteroid 2 / shot 7 -> pair 27, HIT in cycle 29
    clear_all();
    asts[2*ES +: ES]  = ent(1'b1, 100, 50);
    shots[7*ES +: ES] = ent(1'b1, 105, 60);
    scan();
    exp_hits = sat(exp_hits + 1);
    check("one_ndel", n_del, 1);
    check("one_del_at", del_at, 29);
    check("one_pair", pair_err, 0);
    check("one_saddr", last_sa, 7);
    check("one_aaddr", last_aa, 2);
    check("one_done_at", done_at, 42);
    check("one_busy_cnt", busy_cnt, 41);
    check("one_hits", hit_count, exp_hits);
    check("one_addr_hold", {shot_address, asteroid_address}, {4'd7, 2'd2});

    // Hitbox boundaries, including the top of the 10-bit range
    for (int i = 0; i < 8; i++) begin
      clear_all();
      asts[0*ES +: ES]  = ent(1'b1, bx[i], by[i]);
      shots[0*ES +: ES] = ent(1'b1, sxv[i], syv[i]);
      scan();
      exp_hits = sat(exp_hits + bh[i]);
      check($sformatf("bnd%0d_ndel", i), n_del, bh[i]);
      check($sformatf("bnd%0d_hits", i), hit_count, exp_hits);
    end

    // Two shots in one asteroid: lowest shot index wins
    clear_all();
    asts[0*ES +: ES]  = ent(1'b1, 300, 300);
    shots[1*ES +: ES] = ent(1'b1, 301, 301);
    shots[3*ES +: ES] = ent(1'b1, 310, 310);
    scan();
    exp_hits = sat(exp_hits + 1);
    check("multi_ndel", n_del, 1);
    check("multi_saddr", last_sa, 1);
    check("multi_aaddr", last_aa, 0);
    check("multi_hits", hit_count, exp_hits);

    // One shot in two overlapping asteroids: lowest asteroid index wins
    clear_all();
    asts[1*ES +: ES]  = ent(1'b1, 400, 400);
    asts[3*ES +: ES]  = ent(1'b1, 405, 405);
    shots[4*ES +: ES] = ent(1'b1, 410, 410);
    scan();
    exp_hits = sat(exp_hits + 1);
    check("ovl_ndel", n_del, 1);
    check("ovl_aaddr", last_aa, 1);
    check("ovl_saddr", last_sa, 4);

    // Snapshot isolation and ignored second start
    clear_all();
    asts[0*ES +: ES]  = ent(1'b1, 200, 200);
    shots[5*ES +: ES] = ent(1'b1, 205, 205);
    mon_alt = 1'b1;
    alt_shots = '0;
    mon_start_k = 10;
    scan();
    exp_hits = sat(exp_hits + 1);
    check("snap_ndel", n_del, 1);
    check("snap_saddr", last_sa, 5);
    check("snap_ndone", n_done, 1);
    check("snap_done_at", done_at, 42);
    check("snap_hits", hit_count, exp_hits);

    // Reset mid-scan before a pending hit at pair 30
    clear_all();
    asts[3*ES +: ES]  = ent(1'b1, 300, 300);
    shots[0*ES +: ES] = ent(1'b1, 300, 300);
    mon_rst_k = 20;
    scan();
    exp_hits = 0;
    check("rstm_ndel", n_del, 0);
    check("rstm_ndone", n_done, 0);
    check("rstm_hits", hit_count, exp_hits);

    // Saturation: four hits per scan (shot 4 duplicates asteroid 0 and must miss)
    clear_all();
    for (int i = 0; i < 4; i++) begin
      asts[i*ES +: ES]  = ent(1'b1, 100 * i, 0);
      shots[i*ES +: ES] = ent(1'b1, 100 * i + 3, 4);
    end
    shots[4*ES +: ES] = ent(1'b1, 8, 8);
    total_del = 0;
    for (int r = 0; r < 63; r++) begin
      scan();
      total_del += n_del;
    end
    exp_hits = sat(exp_hits + 252);
    check("sat_total_del", total_del, 252);
    check("sat_done_at", done_at, 45);
    check("sat_hits_252", hit_count, exp_hits);
    scan();
    exp_hits = sat(exp_hits + 4);
    check("sat_hits_255", hit_count, exp_hits);
    scan();
    exp_hits = sat(exp_hits + 4);
    check("sat_ndel", n_del, 4);
    check("sat_hits_hold", hit_count, exp_hits);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/entity_collision_checker.md
Name: entity_collision_checker

Overview:
- Reads the packed shot and asteroid entity arrays written by the shot and asteroid controllers, and detects shot/asteroid overlaps.
- Issues the single-cycle delete_shot/shot_address and delete_asteroid/asteroid_address pulses those controllers consume, and keeps a running hit count for scoring.
- Runs one full scan per start pulse, normally once per frame, from a snapshot of both arrays.

Parameters:
SHOT_COUNT, 10, number of shot entity slots
ASTEROID_COUNT, 4, number of asteroid entity slots
ENTITY_SIZE, 34, bits per entity
ASTEROID_SIZE, 16, asteroid hitbox edge length in pixels (square, anchored at entity x/y)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name)
start  in  1  begin a scan; sampled only in IDLE
shots_data  in  SHOT_COUNT x ENTITY_SIZE  packed shot entities
asteroids_data  in  ASTEROID_COUNT x ENTITY_SIZE  packed asteroid entities
delete_shot  out  1  one-cycle pulse: clear shot slot shot_address
shot_address  out  $clog2(SHOT_COUNT)  slot index for delete_shot
delete_asteroid  out  1  one-cycle pulse: clear asteroid slot asteroid_address
asteroid_address  out  $clog2(ASTEROID_COUNT)  slot index for delete_asteroid
hit_count  out  8  cumulative hits, saturating
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse at scan end

Behaviour:
- Entity fields: [33] valid; [32:30] type; [29:28] y step queue; [27:26] x step queue; [25:16] y pos; [15:6] x pos; [5:0] direction. This block reads only valid, x and y.
- Reset: state IDLE. delete_shot, delete_asteroid, shot_address, asteroid_address, hit_count, busy and done all 0. Snapshot and indices cleared. Reset mid-scan aborts immediately; no further deletes are issued.
- States:
  - IDLE: start=1 at a rising edge captures shots_data and asteroids_data into internal snapshot registers, sets a=0 and s=0, and moves to COMPARE. busy=1 from the next cycle.
  - COMPARE: evaluates one pair (asteroid a, shot s) per cycle, ordered a outer and s inner. Hit = snap_ast[a].valid & snap_shot[s].valid & sx>=ax & sx<ax+ASTEROID_SIZE & sy>=ay & sy<ay+ASTEROID_SIZE.
    - Sums are computed at 11 bits; no wrap.
    - On a hit: register the addresses, go to HIT.
    - Otherwise: advance the index. After the last pair (a=ASTEROID_COUNT-1, s=SHOT_COUNT-1), go to DONE.
  - HIT: 1 cycle.
    - delete_shot=1 and delete_asteroid=1 together, with shot_address=s and asteroid_address=a.
    - Clear both snapshot valid bits, so a consumed shot cannot hit again and a destroyed asteroid cannot be hit again.
    - hit_count+1, saturating at 255.
    - Advance the index, then go to COMPARE, or DONE if that was the last pair.
  - DONE: done=1 for 1 cycle, busy=0. Return to IDLE.
- Timing, with start sampled at edge t0:
  - COMPARE occupies cycles t0+1 .. t0+N, where N = SHOT_COUNT*ASTEROID_COUNT. Each hit inserts one HIT cycle.
  - done is high in cycle t0+N+H+1, where H is the number of hits in the scan.
  - Default parameters with no hits: done at t0+41.
- Addresses hold their last value when not pulsing. Only the delete_* pulses qualify them.
- start while busy or in DONE is ignored, not queued.
- Live input changes during a scan have no effect; only the snapshot is used.
- Multiple shots inside one asteroid: only the lowest-indexed valid shot is deleted.
- One shot inside overlapping asteroids: only the lowest-indexed asteroid is deleted.
- Invalid entities never hit, regardless of position.

Test Plan:
- All entities invalid, start at t0 -> no delete pulses; busy high t0+1..t0+40; done high at t0+41 only; hit_count=0.
- Asteroid 2 valid at x=100,y=50; shot 7 valid at x=105,y=60 -> single cycle with delete_asteroid=1, asteroid_address=2, delete_shot=1, shot_address=7; hit_count=1; done at t0+42.
- Boundary, asteroid 0 at x=100,y=100:
  - Shot at x=115,y=115 -> hit.
  - Shot at x=116,y=100 -> no hit.
  - Shot at x=99 -> no hit.
- Shots 1 and 3 both inside asteroid 0 -> exactly one pulse pair (asteroid_address=0, shot_address=1); shot 3 not deleted; hit_count=1.
- Second start pulse at t0+10, plus inputs changed mid-scan to remove the overlap -> second start ignored; the hit from the snapshot is still reported; exactly one done.
- reset_n asserted mid-scan (t0+20) with a pending hit at pair index 30 -> outputs 0 immediately, no delete pulse, no done. hit_count=255 preset by 255 prior hits plus one more hit -> stays 255.
